// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//   Input-side conditioning for the GPIO pads. Each bit is synchronised into
//   the ext_clk_100 domain. It is then optionally debounced to give a clean
//   level. Edges of the clean level are latched as sticky pending flags, and
//   one maskable interrupt request is derived from those flags.
//
// Ports
//   ext_clk_100  board clock (only clock)
//   ext_rst_n    asynchronous active-low reset
//   pad_in       raw asynchronous pad levels
//   debounce_en  per-bit debounce enable (0 = bypass, 1-cycle latency)
//   rise_mask    per-bit rising-edge interrupt enable
//   fall_mask    per-bit falling-edge interrupt enable
//   clr_rise     write-1-to-clear pulse for rise_pend (a set in the same cycle wins)
//   clr_fall     write-1-to-clear pulse for fall_pend (a set in the same cycle wins)
//   in_sync      last synchroniser stage
//   in_clean     conditioned level
//   rise_pend    sticky rising-edge flags
//   fall_pend    sticky falling-edge flags
//   irq          registered OR of enabled pending flags
module gpio_in_conditioner #(
  parameter int WIDTH           = 24,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             ext_clk_100,
  input  logic             ext_rst_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] debounce_en,
  input  logic [WIDTH-1:0] rise_mask,
  input  logic [WIDTH-1:0] fall_mask,
  input  logic [WIDTH-1:0] clr_rise,
  input  logic [WIDTH-1:0] clr_fall,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] in_clean,
  output logic [WIDTH-1:0] rise_pend,
  output logic [WIDTH-1:0] fall_pend,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpio_in_conditioner: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("gpio_in_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_p1 [WIDTH];
  logic [WIDTH-1:0] clean_p1;
  logic [WIDTH-1:0] clean_p2;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;

  // Synchroniser chain: stage 0 samples the pad, the last stage is in_sync
  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= pad_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign in_sync = sync_p[SYNC_STAGES-1];

  // Debounce stage: the count reaches CNT_LAST after DEBOUNCE_CYCLES-1 edges
  // of sustained difference. The level is accepted on the next edge, which
  // gives exactly DEBOUNCE_CYCLES cycles of latency.
  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_p1[i] <= '0;
      clean_p1 <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!debounce_en[i]) begin
          cnt_p1[i]   <= '0;
          clean_p1[i] <= in_sync[i];
        end else if (in_sync[i] == clean_p1[i]) begin
          cnt_p1[i] <= '0;
        end else if (cnt_p1[i] == CNT_LAST) begin
          cnt_p1[i]   <= '0;
          clean_p1[i] <= in_sync[i];
        end else begin
          cnt_p1[i] <= cnt_p1[i] + 1'b1;
        end
      end
    end
  end

  assign in_clean = clean_p1;

  // Edge detection against the previous clean level. Reset clears both
  // registers, so reset itself never produces an edge.
  assign rise_evt = clean_p1 & ~clean_p2;
  assign fall_evt = ~clean_p1 & clean_p2;

  // Pending flag stage: a set in the same cycle as a clear wins
  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      clean_p2  <= '0;
      rise_pend <= '0;
      fall_pend <= '0;
    end else begin
      clean_p2  <= clean_p1;
      rise_pend <= (rise_pend & ~clr_rise) | rise_evt;
      fall_pend <= (fall_pend & ~clr_fall) | fall_evt;
    end
  end

  // Interrupt stage: masks gate only the request, never the flags
  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |((rise_pend & rise_mask) | (fall_pend & fall_mask));
    end
  end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
module tb_gpio_in_conditioner;

  localparam int WIDTH = 24;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] pad_in, debounce_en, rise_mask, fall_mask, clr_rise, clr_fall;
  logic [WIDTH-1:0] in_sync, in_clean, rise_pend, fall_pend;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  gpio_in_conditioner #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .ext_clk_100(clk),
    .ext_rst_n  (rst_n),
    .pad_in     (pad_in),
    .debounce_en(debounce_en),
    .rise_mask  (rise_mask),
    .fall_mask  (fall_mask),
    .clr_rise   (clr_rise),
    .clr_fall   (clr_fall),
    .in_sync    (in_sync),
    .in_clean   (in_clean),
    .rise_pend  (rise_pend),
    .fall_pend  (fall_pend),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    pad_in = '0; debounce_en = '0; rise_mask = '0; fall_mask = '0;
    clr_rise = '0; clr_fall = '0;
    cyc(3);
    chk("rst_sync",  in_sync,   0);
    chk("rst_clean", in_clean,  0);
    chk("rst_rise",  rise_pend, 0);
    chk("rst_fall",  fall_pend, 0);
    chk("rst_irq",   irq,       0);
    rst_n = 1'b1;
    cyc(2);

    // Bypass latency on bit 0
    pad_in[0] = 1'b1;
    cyc(1); chk("byp_sync_c1",  in_sync[0], 0);
    cyc(1); chk("byp_sync_c2",  in_sync[0], 1);
            chk("byp_clean_c2", in_clean[0], 0);
    cyc(1); chk("byp_clean_c3", in_clean[0], 1);
            chk("byp_rise_c3",  rise_pend[0], 0);
    cyc(1); chk("byp_rise_c4",  rise_pend[0], 1);
    cyc(1); chk("byp_irq_unmasked", irq, 0);

    // Debounce accept on bit 5, irq unmasked
    debounce_en[5] = 1'b1;
    rise_mask[5]   = 1'b1;
    pad_in[5]      = 1'b1;
    cyc(5); chk("deb_clean_c5", in_clean[5], 0);
    cyc(1); chk("deb_clean_c6", in_clean[5], 1);
            chk("deb_rise_c6",  rise_pend[5], 0);
    cyc(1); chk("deb_rise_c7",  rise_pend[5], 1);
            chk("deb_irq_c7",   irq, 0);
    cyc(1); chk("deb_irq_c8",   irq, 1);
    rise_mask = '0;
    clr_rise  = '1;
    cyc(1); chk("clr_all_rise", rise_pend, 0);
    clr_rise  = '0;
    cyc(1); chk("irq_after_clr", irq, 0);

    // Glitch reject on bit 7: 3 cycles high is too short
    debounce_en[7] = 1'b1;
    pad_in[7] = 1'b1;
    cyc(3);
    pad_in[7] = 1'b0;
    cyc(8);
    chk("glitch_clean", in_clean[7], 0);
    chk("glitch_rise",  rise_pend[7], 0);
    // 4 cycles high is accepted
    pad_in[7] = 1'b1;
    cyc(4);
    pad_in[7] = 1'b0;
    cyc(1); chk("acc_clean_c5", in_clean[7], 0);
    cyc(1); chk("acc_clean_c6", in_clean[7], 1);
    cyc(1); chk("acc_rise_c7",  rise_pend[7], 1);
    // in_sync has been low since edge 6, so the level falls 4 edges later
    cyc(3); chk("acc_clean_c10", in_clean[7], 0);
    cyc(1); chk("acc_fall_c11",  fall_pend[7], 1);
    clr_rise = '1; clr_fall = '1;
    cyc(1);
    clr_rise = '0; clr_fall = '0;
    chk("clr_rise_all", rise_pend, 0);
    chk("clr_fall_all", fall_pend, 0);

    // Set/clear collision on bit 2 (bypass)
    pad_in[2] = 1'b1;
    cyc(5);
    chk("col_rise_pre", rise_pend[2], 1);
    clr_rise[2] = 1'b1;
    cyc(1);
    clr_rise[2] = 1'b0;
    chk("col_rise_clr", rise_pend[2], 0);
    clr_fall[2] = 1'b1;
    pad_in[2]   = 1'b0;
    cyc(3); chk("col_clean_fell", in_clean[2], 0);
            chk("col_fall_c3",    fall_pend[2], 0);
    cyc(1); chk("col_fall_setwins", fall_pend[2], 1);
    cyc(1); chk("col_fall_cleared", fall_pend[2], 0);
    clr_fall[2] = 1'b0;

    // Masking and irq on bit 3
    pad_in[3] = 1'b1;
    cyc(5);
    chk("msk_rise",   rise_pend[3], 1);
    chk("msk_irq_off", irq, 0);
    rise_mask[3] = 1'b1;
    cyc(1); chk("msk_irq_on", irq, 1);
    clr_rise[3] = 1'b1;
    cyc(1);
    clr_rise[3] = 1'b0;
    chk("msk_rise_clr",  rise_pend[3], 0);
    chk("msk_irq_lag",   irq, 1);
    cyc(1); chk("msk_irq_drop", irq, 0);
    rise_mask = '0;

    // Asynchronous reset with bit 9 counter at 2
    debounce_en[9] = 1'b1;
    pad_in[9] = 1'b1;
    cyc(4);
    chk("ar_clean_pre", in_clean[9], 0);
    rst_n = 1'b0;
    #1;
    chk("ar_sync0",  in_sync,   0);
    chk("ar_clean0", in_clean,  0);
    chk("ar_rise0",  rise_pend, 0);
    chk("ar_fall0",  fall_pend, 0);
    chk("ar_irq0",   irq,       0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5); chk("ar_clean_c5", in_clean[9], 0);
    cyc(1); chk("ar_clean_c6", in_clean[9], 1);
    cyc(1); chk("ar_rise_c7",  rise_pend[9], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
